// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared types and widths for the motion bounding-box path.
//   COORD_W  : width of a pixel coordinate (x or y)
//   CNT_W    : width of the per-frame set-pixel counter
//   state_e  : frame tracking FSM states
//   coord_t  : bounding box {xmin, xmax, ymin, ymax}
//   sat_inc  : saturating increment for the pixel counter
// -----------------------------------------------------------------------------
package motion_pkg;

   localparam int COORD_W = 10;
   localparam int CNT_W   = 19;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef struct packed {
      logic [COORD_W-1:0] xmin;
      logic [COORD_W-1:0] xmax;
      logic [COORD_W-1:0] ymin;
      logic [COORD_W-1:0] ymax;
   } coord_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// -----------------------------------------------------------------------------
// pixel_coord_counter
// Tracks the (x, y) position of the current pixel in a vsync/href/clken video
// stream and produces the frame/line edge strobes used by downstream stages.
//   clk, rst_n   : pixel clock, synchronous active-low reset
//   vsync_i      : frame sync, high for the whole frame
//   href_i       : line valid
//   clken_i      : pixel valid strobe
//   clr_i        : restart both counters at a new frame
//   active_i     : line counting enabled (frame being tracked)
//   vs_rise_o    : frame start strobe
//   vs_fall_o    : frame end strobe
//   x_o, y_o     : coordinate of the pixel presented this cycle
//   in_range_o   : x_o/y_o lie inside the active image
// -----------------------------------------------------------------------------
module pixel_coord_counter
   import motion_pkg::*;
#(
   parameter logic [COORD_W-1:0] IMG_HDISP = 10'd640,
   parameter logic [COORD_W-1:0] IMG_VDISP = 10'd480
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync_i,
   input  logic               href_i,
   input  logic               clken_i,
   input  logic               clr_i,
   input  logic               active_i,
   output logic               vs_rise_o,
   output logic               vs_fall_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               in_range_o
);

   logic               vsync_q;
   logic               href_q;
   logic               armed_q;
   logic               hs_fall;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   // A frame already under way when reset is released must not look like a
   // fresh start: a rising vsync is only honoured once vsync has been seen low.
   assign vs_rise_o = vsync_i & ~vsync_q & armed_q;
   assign vs_fall_o = ~vsync_i & vsync_q;
   assign hs_fall   = ~href_i & href_q;

   always_comb begin
      x_d = x_q;
      if (clr_i || hs_fall) begin
         x_d = '0;
      end else if (href_i && clken_i && (x_q < IMG_HDISP)) begin
         // Saturates at IMG_HDISP so over-long lines never wrap back into range.
         x_d = x_q + COORD_W'(1);
      end
   end

   always_comb begin
      y_d = y_q;
      if (clr_i) begin
         y_d = '0;
      end else if (hs_fall && active_i && (y_q < IMG_VDISP)) begin
         y_d = y_q + COORD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         armed_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         vsync_q <= vsync_i;
         href_q  <= href_i;
         if (!vsync_i) begin
            armed_q <= 1'b1;
         end
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o        = x_q;
   assign y_o        = y_q;
   assign in_range_o = (x_q < IMG_HDISP) && (y_q < IMG_VDISP);

endmodule

// File: rtl/motion_bbox_detect.sv
// -----------------------------------------------------------------------------
// motion_bbox_detect
// Collects the bounding box and count of set pixels in a binary motion mask
// and publishes them once per frame.
//   clk, rst_n       : pixel clock, synchronous active-low reset
//   per_frame_vsync  : frame sync (high for the whole frame)
//   per_frame_href   : line valid
//   per_frame_clken  : pixel valid strobe
//   per_img_Bit      : mask pixel, 1 = motion
//   box_valid        : one-cycle pulse, new frame result on the outputs
//   box_found        : pixel_cnt reached MIN_PIXELS
//   box_xmin/xmax    : horizontal extent (0 when not found)
//   box_ymin/ymax    : vertical extent (0 when not found)
//   pixel_cnt        : set-pixel count of the last frame
// -----------------------------------------------------------------------------
module motion_bbox_detect
   import motion_pkg::*;
#(
   parameter logic [COORD_W-1:0] IMG_HDISP  = 10'd640,
   parameter logic [COORD_W-1:0] IMG_VDISP  = 10'd480,
   parameter logic [CNT_W-1:0]   MIN_PIXELS = 19'd16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               per_frame_vsync,
   input  logic               per_frame_href,
   input  logic               per_frame_clken,
   input  logic               per_img_Bit,
   output logic               box_valid,
   output logic               box_found,
   output logic [COORD_W-1:0] box_xmin,
   output logic [COORD_W-1:0] box_xmax,
   output logic [COORD_W-1:0] box_ymin,
   output logic [COORD_W-1:0] box_ymax,
   output logic [CNT_W-1:0]   pixel_cnt
);

   logic               vs_rise;
   logic               vs_fall;
   logic [COORD_W-1:0] x_cnt;
   logic [COORD_W-1:0] y_cnt;
   logic               in_range;

   state_e             state_q, state_d;
   logic               clr_acc;
   logic               active;
   logic               set_pix;
   logic               publish;

   coord_t             acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   coord_t             box_q, box_d;
   logic               found_q, found_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   pcnt_q, pcnt_d;

   pixel_coord_counter #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_coord (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync_i    (per_frame_vsync),
      .href_i     (per_frame_href),
      .clken_i    (per_frame_clken),
      .clr_i      (clr_acc),
      .active_i   (active),
      .vs_rise_o  (vs_rise),
      .vs_fall_o  (vs_fall),
      .x_o        (x_cnt),
      .y_o        (y_cnt),
      .in_range_o (in_range)
   );

   assign active  = (state_q == ACTIVE);
   assign clr_acc = (state_q == IDLE) && vs_rise;
   assign set_pix = active && per_frame_href && per_frame_clken && per_img_Bit && in_range;
   // Results are loaded on the edge that enters DONE, so box_valid and the
   // new box are visible together for exactly the DONE cycle.
   assign publish = active && vs_fall;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vs_rise) state_d = ACTIVE;
         ACTIVE:  if (vs_fall) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr_acc) begin
         acc_d.xmin = IMG_HDISP - COORD_W'(1);
         acc_d.xmax = '0;
         acc_d.ymin = IMG_VDISP - COORD_W'(1);
         acc_d.ymax = '0;
         cnt_d      = '0;
      end else if (set_pix) begin
         if (x_cnt < acc_q.xmin) acc_d.xmin = x_cnt;
         if (x_cnt > acc_q.xmax) acc_d.xmax = x_cnt;
         if (y_cnt < acc_q.ymin) acc_d.ymin = y_cnt;
         if (y_cnt > acc_q.ymax) acc_d.ymax = y_cnt;
         cnt_d = sat_inc(cnt_q);
      end
   end

   always_comb begin
      valid_d = 1'b0;
      found_d = found_q;
      box_d   = box_q;
      pcnt_d  = pcnt_q;
      if (publish) begin
         valid_d = 1'b1;
         pcnt_d  = cnt_d;
         if (cnt_d >= MIN_PIXELS) begin
            found_d = 1'b1;
            box_d   = acc_d;
         end else begin
            found_d = 1'b0;
            box_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         box_q   <= '0;
         found_q <= 1'b0;
         valid_q <= 1'b0;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         box_q   <= box_d;
         found_q <= found_d;
         valid_q <= valid_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign box_valid = valid_q;
   assign box_found = found_q;
   assign box_xmin  = box_q.xmin;
   assign box_xmax  = box_q.xmax;
   assign box_ymin  = box_q.ymin;
   assign box_ymax  = box_q.ymax;
   assign pixel_cnt = pcnt_q;

endmodule

// File: doc/motion_bbox_detect.md
Name: motion_bbox_detect

Overview:
- Sits directly downstream of the 5x5 erosion stage.
- Consumes the cleaned binary motion mask (vsync/href/clken/bit) and tracks the pixel coordinates of every set pixel in a frame.
- At end of frame, publishes the motion bounding box (xmin/xmax/ymin/ymax) and the set-pixel count.
- Results feed the box-overlay / display stage.

Parameters:
- IMG_HDISP, 10'd640, active pixels per line; x range 0..IMG_HDISP-1.
- IMG_VDISP, 10'd480, active lines per frame; y range 0..IMG_VDISP-1.
- MIN_PIXELS, 19'd16, minimum set-pixel count for a box to be declared found (noise gate).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low.
- per_frame_vsync  in  1  frame sync; high for the whole frame.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel valid strobe.
- per_img_Bit  in  1  eroded mask pixel (1 = motion).
- box_valid  out  1  one-cycle pulse: new frame result published.
- box_found  out  1  1 = pixel_cnt >= MIN_PIXELS in the last frame.
- box_xmin  out  10  left edge; 0 when not found.
- box_xmax  out  10  right edge; 0 when not found.
- box_ymin  out  10  top edge; 0 when not found.
- box_ymax  out  10  bottom edge; 0 when not found.
- pixel_cnt  out  19  set-pixel count of the last frame.

Behaviour:
- Reset, synchronous on rst_n=0 at the clock edge:
  - All outputs 0.
  - x/y counters and accumulators cleared.
  - vsync_d/href_d cleared.
  - FSM to IDLE.
- Edge detect uses registered vsync_d and href_d:
  - vs_rise = vsync & ~vsync_d; vs_fall = ~vsync & vsync_d.
  - hs_fall = ~href & href_d.
- FSM states:
  - IDLE: wait for vs_rise, then go to ACTIVE. A frame already in progress after reset is ignored entirely.
  - ACTIVE: accumulate. On vs_fall, go to DONE.
  - DONE: one cycle. Latch results to the outputs, box_valid=1, then go to IDLE.
- On vs_rise (IDLE→ACTIVE), clear accumulators:
  - xmin=IMG_HDISP-1, xmax=0, ymin=IMG_VDISP-1, ymax=0, cnt=0.
  - x_cnt=0, y_cnt=0.
- x_cnt:
  - Increments on each cycle with href&clken.
  - Cleared on hs_fall.
  - Saturates at IMG_HDISP; no wrap within a line.
- y_cnt:
  - Increments on hs_fall while ACTIVE.
  - Saturates at IMG_VDISP.
- A pixel is "set" when ACTIVE & href & clken & per_img_Bit & x_cnt<IMG_HDISP & y_cnt<IMG_VDISP. Out-of-range pixels are ignored.
- On each set pixel:
  - xmin=min(xmin,x_cnt), xmax=max(xmax,x_cnt).
  - ymin=min(ymin,y_cnt), ymax=max(ymax,y_cnt).
  - cnt+1, saturating at 2^19-1.
  - The pixel's coordinates are the pre-increment x_cnt and y_cnt.
- DONE publish rules:
  - pixel_cnt=cnt.
  - If cnt >= MIN_PIXELS: box_found=1 and box_* = accumulators.
  - Otherwise: box_found=0 and all box_* = 0.
- Output timing:
  - box_valid rises in the cycle after the edge at which vs_fall is registered; it is exactly 1 cycle wide.
  - box_* and pixel_cnt change only in that DONE cycle and hold until the next DONE or reset.
- Simultaneous events:
  - A set pixel in the same cycle as hs_fall cannot occur, because href must be high.
  - vs_fall while href is still high: the frame ends and the remaining pixels are discarded.
  - vs_rise in DONE: missed. The FSM returns to IDLE and waits for the next frame; one frame is dropped by design.
- Reset mid-frame: the partial frame is discarded, outputs are 0, and the first box_valid comes after the next complete frame.

Decomposition:
- Package motion_pkg:
  - COORD_W=10, CNT_W=19.
  - State enum {IDLE, ACTIVE, DONE}.
  - Coordinate struct {xmin, xmax, ymin, ymax}.
- Sub-module pixel_coord_counter:
  - Contains the edge detect, x_cnt/y_cnt, saturation and in-range flag.
  - Reusable by the overlay stage.
- Top level holds the FSM, min/max accumulators and output registers.

Test Plan:
- Single set pixel at (x=100,y=50), MIN_PIXELS=1 → box_valid pulse; found=1, xmin=xmax=100, ymin=ymax=50, cnt=1.
- 4x4 block at x=200..203, y=10..13 (16 px), MIN_PIXELS=16 → found=1, box (200,203,10,13), cnt=16. Repeat with 15 px → found=0, all box_* =0, cnt=15.
- All-ones 640x480 frame → box (0,639,0,479), cnt=307200, found=1; box_valid exactly 1 cycle after vs_fall registered.
- Set pixels at x=0 and x=639 on lines 0 and 479 with clken gaps (clken 50% duty) → box (0,639,0,479), cnt=4; gaps do not advance x.
- rst_n=0 for 1 cycle mid-frame at line 200 → outputs 0 immediately, no box_valid for that frame; next full frame with pixel (5,5) reports box (5,5,5,5).
- Two back-to-back frames with different boxes → second box_valid reports only the second frame's box; no carry-over of min/max.
